// File: rtl/cycle_term_gen.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cycle_term_gen
//
// Generates the 68040 cycle-termination pair (TACKn / TEAn) for local-bus
// cycles that are bridged to PCI. It handles single-beat and burst transfers,
// ends a stalled cycle with TEA after a programmable number of not-ready
// cycles, and ends a cycle with TEA on an explicit abort. Every cycle finishes
// by driving both lines high for one cycle before the output enable drops, so
// the open lines are never left floating low.
//
// All state updates happen on the falling edge of CLK40.
//
// Parameters:
//   BEATS   - beats per burst cycle (>= 2); non-burst cycles are one beat
//   TO_W    - width of the not-ready timeout counter
//   TIMEOUT - consecutive not-ready cycles before TEA; 0 disables it
//
// Ports:
//   CLK40     in  40 MHz bus clock (falling edge active)
//   RESETn    in  asynchronous active-low reset
//   START     in  cycle-start strobe, only looked at while idle
//   BURST     in  burst qualifier, captured with START
//   RnW       in  direction (1 = read), captured with START
//   rd_ready  in  read data valid for the current beat
//   wr_ready  in  write data accepted for the current beat
//   ABORT     in  target error, ends the cycle with TEA
//   TACK_OUTn out transfer acknowledge, active low
//   TEA_OUTn  out transfer error acknowledge, active low
//   TERM_EN   out output enable for both termination lines
//   BEAT      out index of the current beat
//   BUSY      out high whenever a cycle is in progress
//   ERR       out one-cycle pulse coinciding with TEA
// ---------------------------------------------------------------------------
module cycle_term_gen #(
    parameter int BEATS   = 4,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic                     CLK40,
    input  logic                     RESETn,
    input  logic                     START,
    input  logic                     BURST,
    input  logic                     RnW,
    input  logic                     rd_ready,
    input  logic                     wr_ready,
    input  logic                     ABORT,
    output logic                     TACK_OUTn,
    output logic                     TEA_OUTn,
    output logic                     TERM_EN,
    output logic [$clog2(BEATS)-1:0] BEAT,
    output logic                     BUSY,
    output logic                     ERR
);

    localparam int              BW        = $clog2(BEATS);
    localparam logic [BW-1:0]   LAST_BEAT = BW'(BEATS - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam bit              TO_ENABLE = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_ERROR,
        S_NEGATE,
        S_RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic            tack_q, tack_d;
    logic            tea_q, tea_d;
    logic            term_en_q, term_en_d;
    logic            err_q, err_d;
    logic            burst_q, burst_d;
    logic            rnw_q, rnw_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [TO_W-1:0] timer_q, timer_d;

    logic go;
    logic last_beat;
    logic timeout_hit;

    // Readiness follows the captured direction, never the live RnW pin.
    assign go          = rnw_q ? rd_ready : wr_ready;
    assign last_beat   = burst_q ? (beat_q == LAST_BEAT) : (beat_q == '0);
    assign timeout_hit = TO_ENABLE && (timer_q == TO_LAST) && !go;

    // State register and all output/latch flops.
    always_ff @(negedge CLK40 or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= S_IDLE;
            tack_q    <= 1'b1;
            tea_q     <= 1'b1;
            term_en_q <= 1'b0;
            err_q     <= 1'b0;
            burst_q   <= 1'b0;
            rnw_q     <= 1'b0;
            beat_q    <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            tack_q    <= tack_d;
            tea_q     <= tea_d;
            term_en_q <= term_en_d;
            err_q     <= err_d;
            burst_q   <= burst_d;
            rnw_q     <= rnw_d;
            beat_q    <= beat_d;
            timer_q   <= timer_d;
        end
    end

    // Next-state logic. Abort and timeout take priority over an acknowledge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (START) state_d = S_DATA;
            S_DATA: begin
                if (ABORT || timeout_hit) begin
                    state_d = S_ERROR;
                end else if (go && last_beat) begin
                    state_d = S_NEGATE;
                end
            end
            S_ERROR:   state_d = S_NEGATE;
            S_NEGATE:  state_d = S_RELEASE;
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output and datapath logic. TEA is low only for the single ERROR cycle;
    // NEGATE then re-drives both lines high before RELEASE drops the enable.
    always_comb begin
        tack_d    = tack_q;
        tea_d     = tea_q;
        term_en_d = term_en_q;
        err_d     = 1'b0;
        burst_d   = burst_q;
        rnw_d     = rnw_q;
        beat_d    = beat_q;
        timer_d   = timer_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    burst_d   = BURST;
                    rnw_d     = RnW;
                    beat_d    = '0;
                    timer_d   = '0;
                    term_en_d = 1'b1;
                    tack_d    = 1'b1;
                    tea_d     = 1'b1;
                end
            end
            S_DATA: begin
                if (ABORT || timeout_hit) begin
                    tea_d  = 1'b0;
                    tack_d = 1'b1;
                    err_d  = 1'b1;
                end else if (go) begin
                    tack_d  = 1'b0;
                    timer_d = '0;
                    if (!last_beat) begin
                        beat_d = beat_q + BW'(1);
                    end
                end else begin
                    tack_d = 1'b1;
                    if (timer_q != '1) begin
                        timer_d = timer_q + TO_W'(1);
                    end
                end
            end
            S_ERROR: begin
                tea_d = 1'b1;
            end
            S_NEGATE: begin
                tack_d = 1'b1;
                tea_d  = 1'b1;
            end
            S_RELEASE: begin
                term_en_d = 1'b0;
                beat_d    = '0;
            end
            default: begin
                term_en_d = 1'b0;
            end
        endcase
    end

    assign TACK_OUTn = tack_q;
    assign TEA_OUTn  = tea_q;
    assign TERM_EN   = term_en_q;
    assign BEAT      = beat_q;
    assign BUSY      = (state_q != S_IDLE);
    assign ERR       = err_q;

endmodule

// File: tb/tb_cycle_term_gen.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_cycle_term_gen
//
// Self-checking bench for cycle_term_gen. A behavioural model tracks a cycle
// as "beats acknowledged", "consecutive stall count" and "tail cycles left
// before release", and predicts every output after each falling edge. Inputs
// change and outputs are compared just after the rising edge, half a period
// away from the falling edge the design acts on. A second instance with the
// timeout disabled is exercised separately.
// ---------------------------------------------------------------------------
module tb_cycle_term_gen;

    localparam int BEATS   = 4;
    localparam int TO_W    = 8;
    localparam int TIMEOUT = 200;
    localparam int BW      = $clog2(BEATS);

    logic          CLK40 = 1'b0;
    logic          RESETn;
    logic          START, BURST, RnW, rd_ready, wr_ready, ABORT;
    logic          TACK_OUTn, TEA_OUTn, TERM_EN, BUSY, ERR;
    logic [BW-1:0] BEAT;

    // Second instance, timeout disabled, with its own stimulus.
    logic          start2, burst2, rnw2, rd2, wr2, abort2;
    logic          tack2, tea2, term2, busy2, err2;
    logic [BW-1:0] beat2;

    int n_vec  = 0;
    int n_fail = 0;

    // Model state and predicted outputs.
    logic          m_busy  = 1'b0;
    logic          m_burst = 1'b0;
    logic          m_rnw   = 1'b0;
    int            m_beats = 0;
    int            m_stall = 0;
    int            m_tail  = 0;
    logic          e_tack  = 1'b1;
    logic          e_tea   = 1'b1;
    logic          e_term  = 1'b0;
    logic          e_err   = 1'b0;
    logic [BW-1:0] e_beat  = '0;

    logic [BW+4:0] obs_v, exp_v;
    assign obs_v = {TACK_OUTn, TEA_OUTn, TERM_EN, BEAT, BUSY, ERR};
    assign exp_v = {e_tack, e_tea, e_term, e_beat, m_busy, e_err};

    always #10 CLK40 = ~CLK40;

    cycle_term_gen #(.BEATS(BEATS), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) u_dut (
        .CLK40(CLK40), .RESETn(RESETn), .START(START), .BURST(BURST), .RnW(RnW),
        .rd_ready(rd_ready), .wr_ready(wr_ready), .ABORT(ABORT),
        .TACK_OUTn(TACK_OUTn), .TEA_OUTn(TEA_OUTn), .TERM_EN(TERM_EN),
        .BEAT(BEAT), .BUSY(BUSY), .ERR(ERR)
    );

    cycle_term_gen #(.BEATS(BEATS), .TO_W(TO_W), .TIMEOUT(0)) u_dut_nt (
        .CLK40(CLK40), .RESETn(RESETn), .START(start2), .BURST(burst2), .RnW(rnw2),
        .rd_ready(rd2), .wr_ready(wr2), .ABORT(abort2),
        .TACK_OUTn(tack2), .TEA_OUTn(tea2), .TERM_EN(term2),
        .BEAT(beat2), .BUSY(busy2), .ERR(err2)
    );

    task automatic model_reset();
        m_busy  = 1'b0;
        m_beats = 0;
        m_stall = 0;
        m_tail  = 0;
        e_tack  = 1'b1;
        e_tea   = 1'b1;
        e_term  = 1'b0;
        e_err   = 1'b0;
        e_beat  = '0;
    endtask

    task automatic model_edge();
        logic g;
        e_err = 1'b0;
        if (!m_busy) begin
            if (START) begin
                m_busy  = 1'b1;
                m_burst = BURST;
                m_rnw   = RnW;
                m_beats = 0;
                m_stall = 0;
                m_tail  = 0;
                e_term  = 1'b1;
                e_beat  = '0;
            end
        end else if (m_tail == 0) begin
            g = m_rnw ? rd_ready : wr_ready;
            if (ABORT || (TIMEOUT != 0 && m_stall == TIMEOUT - 1 && !g)) begin
                e_tea  = 1'b0;
                e_tack = 1'b1;
                e_err  = 1'b1;
                m_tail = 3;
            end else if (g) begin
                e_tack  = 1'b0;
                m_stall = 0;
                m_beats = m_beats + 1;
                if (m_beats == (m_burst ? BEATS : 1)) m_tail = 2;
                else e_beat = BW'(m_beats);
            end else begin
                e_tack = 1'b1;
                if (m_stall < (1 << TO_W) - 1) m_stall = m_stall + 1;
            end
        end else begin
            m_tail = m_tail - 1;
            e_tack = 1'b1;
            e_tea  = 1'b1;
            if (m_tail == 0) begin
                e_term = 1'b0;
                e_beat = '0;
                m_busy = 1'b0;
            end
        end
    endtask

    always @(negedge CLK40 or negedge RESETn) begin
        if (!RESETn) model_reset();
        else         model_edge();
    end

    task automatic idle_inputs();
        START = 1'b0; BURST = 1'b0; RnW = 1'b1;
        rd_ready = 1'b0; wr_ready = 1'b0; ABORT = 1'b0;
        start2 = 1'b0; burst2 = 1'b0; rnw2 = 1'b1;
        rd2 = 1'b0; wr2 = 1'b0; abort2 = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RESETn = 1'b1;
        #2 RESETn = 1'b0;
        #3;
        n_vec++;
        if (obs_v !== {1'b1, 1'b1, 1'b0, {BW{1'b0}}, 1'b0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL reset_values got %b want %b", obs_v,
                     {1'b1, 1'b1, 1'b0, {BW{1'b0}}, 1'b0, 1'b0});
        end
        n_vec++;
        if ({tack2, tea2, term2, busy2, err2} !== 5'b11000) begin
            n_fail++;
            $display("[TB] FAIL reset_values_nt got %b want %b",
                     {tack2, tea2, term2, busy2, err2}, 5'b11000);
        end
        @(posedge CLK40);
        @(posedge CLK40);
        RESETn = 1'b1;
    endtask

    task automatic test_single_read();
        int n_tack = 0;
        int n_err  = 0;
        BURST = 1'b0; RnW = 1'b1; rd_ready = 1'b1; START = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK40);
            START = 1'b0;
            n_vec++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL single_read cyc %0d got %b want %b", i, obs_v, exp_v);
            end
            if (!TACK_OUTn) n_tack++;
            if (ERR) n_err++;
        end
        rd_ready = 1'b0;
        n_vec++;
        if (n_tack !== 1 || n_err !== 0) begin
            n_fail++;
            $display("[TB] FAIL single_read_counts tack=%0d err=%0d want tack=1 err=0", n_tack, n_err);
        end
    endtask

    task automatic test_burst_write();
        int pat[5]   = '{1, 0, 1, 1, 1};
        int beats[5] = '{0, 1, 1, 2, 3};
        int n_tack   = 0;
        BURST = 1'b1; RnW = 1'b0; wr_ready = 1'b0; rd_ready = 1'b0; START = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK40);
            START = 1'b0;
            wr_ready = (i < 5) ? pat[i][0] : 1'b0;
            n_vec++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL burst_write cyc %0d got %b want %b", i, obs_v, exp_v);
            end
            if (i < 5) begin
                n_vec++;
                if (int'(BEAT) !== beats[i]) begin
                    n_fail++;
                    $display("[TB] FAIL burst_beat cyc %0d got %0d want %0d", i, BEAT, beats[i]);
                end
            end
            if (!TACK_OUTn) n_tack++;
        end
        n_vec++;
        if (n_tack !== BEATS) begin
            n_fail++;
            $display("[TB] FAIL burst_tack_count got %0d want %0d", n_tack, BEATS);
        end
    endtask

    task automatic test_latched_dir();
        int n_tack  = 0;
        int n_err   = 0;
        int tea_cyc = -1;
        BURST = 1'b0; RnW = 1'b1; rd_ready = 1'b0; wr_ready = 1'b0; START = 1'b1;
        for (int i = 0; i < TIMEOUT + 8; i++) begin
            @(posedge CLK40);
            START = 1'b0; RnW = 1'b0; wr_ready = 1'b1;
            n_vec++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL latched_dir cyc %0d got %b want %b", i, obs_v, exp_v);
            end
            if (!TACK_OUTn) n_tack++;
            if (ERR) n_err++;
            if (!TEA_OUTn && tea_cyc < 0) tea_cyc = i;
        end
        wr_ready = 1'b0; RnW = 1'b1;
        n_vec++;
        if (n_tack !== 0 || n_err !== 1 || tea_cyc !== TIMEOUT) begin
            n_fail++;
            $display("[TB] FAIL timeout_counts tack=%0d err=%0d tea_at=%0d want 0 1 %0d",
                     n_tack, n_err, tea_cyc, TIMEOUT);
        end
    endtask

    task automatic test_abort_beat2();
        BURST = 1'b1; RnW = 1'b1; rd_ready = 1'b1; START = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge CLK40);
            START = 1'b0;
            ABORT = (i == 2);
            n_vec++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL abort cyc %0d got %b want %b", i, obs_v, exp_v);
            end
            if (i == 3) begin
                n_vec++;
                if ({TACK_OUTn, TEA_OUTn, ERR} !== 3'b101) begin
                    n_fail++;
                    $display("[TB] FAIL abort_tea got %b want 101", {TACK_OUTn, TEA_OUTn, ERR});
                end
            end
            if (i == 6) begin
                n_vec++;
                if ({BUSY, TERM_EN, BEAT} !== {2'b00, {BW{1'b0}}}) begin
                    n_fail++;
                    $display("[TB] FAIL abort_idle got %b want %b", {BUSY, TERM_EN, BEAT},
                             {2'b00, {BW{1'b0}}});
                end
            end
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        int n_tack = 0;
        BURST = 1'b1; RnW = 1'b1; rd_ready = 1'b1; START = 1'b1;
        @(posedge CLK40);
        START = 1'b0;
        @(posedge CLK40);
        n_vec++;
        if (TACK_OUTn !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_setup tack got %b want 0", TACK_OUTn);
        end
        #3 RESETn = 1'b0;
        #1;
        n_vec++;
        if ({TACK_OUTn, TEA_OUTn, TERM_EN, BUSY} !== 4'b1100) begin
            n_fail++;
            $display("[TB] FAIL async_reset got %b want 1100", {TACK_OUTn, TEA_OUTn, TERM_EN, BUSY});
        end
        n_vec++;
        if (obs_v !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL async_reset_model got %b want %b", obs_v, exp_v);
        end
        @(posedge CLK40);
        RESETn = 1'b1;
        BURST = 1'b0; START = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK40);
            START = 1'b0;
            n_vec++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL after_reset cyc %0d got %b want %b", i, obs_v, exp_v);
            end
            if (!TACK_OUTn) n_tack++;
        end
        rd_ready = 1'b0;
        n_vec++;
        if (n_tack !== 1) begin
            n_fail++;
            $display("[TB] FAIL after_reset_tack got %0d want 1", n_tack);
        end
    endtask

    task automatic test_back_to_back();
        int n_tack = 0;
        BURST = 1'b0; RnW = 1'b1; rd_ready = 1'b1; START = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK40);
            n_vec++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL back_to_back cyc %0d got %b want %b", i, obs_v, exp_v);
            end
            if (!TACK_OUTn) n_tack++;
        end
        START = 1'b0;
        for (int i = 0; i < 4; i++) @(posedge CLK40);
        rd_ready = 1'b0;
        n_vec++;
        if (n_tack !== 10) begin
            n_fail++;
            $display("[TB] FAIL back_to_back_count got %0d want 10", n_tack);
        end
    endtask

    task automatic test_no_timeout();
        int n_tack = 0;
        start2 = 1'b1; burst2 = 1'b0; rnw2 = 1'b1; rd2 = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge CLK40);
            start2 = 1'b0;
            n_vec++;
            if ({tea2, busy2, tack2, err2} !== 4'b1110) begin
                n_fail++;
                $display("[TB] FAIL no_timeout_wait cyc %0d got %b want 1110", i, {tea2, busy2, tack2, err2});
            end
        end
        rd2 = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(posedge CLK40);
            if (!tack2) n_tack++;
            n_vec++;
            if (j == 2 && {busy2, term2} !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL no_timeout_done got %b want 00", {busy2, term2});
            end
        end
        rd2 = 1'b0;
        n_vec++;
        if (n_tack !== 1) begin
            n_fail++;
            $display("[TB] FAIL no_timeout_tack got %0d want 1", n_tack);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            START    = ($urandom_range(0, 3) == 0);
            BURST    = $urandom_range(0, 1) == 1;
            RnW      = $urandom_range(0, 1) == 1;
            rd_ready = ($urandom_range(0, 9) < 7);
            wr_ready = ($urandom_range(0, 9) < 7);
            ABORT    = ($urandom_range(0, 39) == 0);
            @(posedge CLK40);
            n_vec++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL random cyc %0d got %b want %b", i, obs_v, exp_v);
            end
            n_vec++;
            if (!TACK_OUTn && !TEA_OUTn) begin
                n_fail++;
                $display("[TB] FAIL both_low cyc %0d got tack=0 tea=0 want not both 0", i);
            end
        end
        idle_inputs();
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog expired before the test sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_burst_write();
        test_latched_dir();
        test_abort_beat2();
        test_async_reset();
        test_back_to_back();
        test_no_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
